trees_spawn_scheduler: RTL and testbench

- Produces the per-tree enable vector consumed by the trees layer.
- At start of level, computes a quota of trees for the level number, then releases trees one at a time into free slots, spaced by pseudo-random gaps counted in tenth-second ticks.
- Tree objects report leaving play through a retire vector, which frees their slot.
- Signals level completion once every released tree has retired.

---
 rtl/trees_spawn_scheduler.sv | 100 ++++++++++
 tb/tb_trees_spawn_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/trees_spawn_scheduler.sv
// trees_spawn_scheduler: releases a per-level quota of trees into free slots at pseudo-random
// tick gaps, tracks retirements and pulses levelDone once the level has fully drained.
module trees_spawn_scheduler #(
    parameter int TREES_COUNT     = 16,
    parameter int BASE_TREES      = 4,
    parameter int TREES_PER_LEVEL = 2,
    parameter int MIN_GAP         = 3,
    parameter int GAP_MASK        = 7,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfLevel,
    input  logic                   endLevel,
    input  logic                   oneTensSec,
    input  logic [3:0]             levelNumber,
    input  logic [TREES_COUNT-1:0] treeRetireVector,
    output logic [TREES_COUNT-1:0] enableTreesVector,
    output logic [4:0]             releasedCount,
    output logic                   busy,
    output logic                   levelDone
);
    typedef enum logic [1:0] {IDLE, WAIT_GAP, RELEASE, DRAIN} state_t;

    state_t                 r_state;
    logic [15:0]            r_lfsr;
    logic [4:0]             r_quota;
    logic [4:0]             r_gap;
    logic [4:0]             r_cnt;
    logic [TREES_COUNT-1:0] r_vec;
    logic                   r_done;

    logic [5:0]             w_quota_raw;
    logic [4:0]             w_quota;
    logic [4:0]             w_gap_load;
    logic [4:0]             w_cnt_inc;
    logic [TREES_COUNT-1:0] w_rel;
    logic [TREES_COUNT-1:0] w_vec_next;
    logic                   w_fb;

    assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_quota_raw = 6'(BASE_TREES) + 6'(TREES_PER_LEVEL) * {2'b00, levelNumber};
    assign w_quota     = (w_quota_raw > 6'(TREES_COUNT)) ? 5'(TREES_COUNT) : w_quota_raw[4:0];
    assign w_gap_load  = 5'(MIN_GAP) + {1'b0, r_lfsr[3:0] & 4'(GAP_MASK)};
    assign w_cnt_inc   = r_cnt + 5'd1;
    // lowest zero bit of the vector as it stood at the start of the cycle
    assign w_rel       = (r_state == RELEASE) ? (~r_vec & (r_vec + 1'b1)) : '0;
    assign w_vec_next  = (r_vec & ~treeRetireVector) | w_rel;

    assign enableTreesVector = r_vec;
    assign releasedCount     = r_cnt;
    assign busy              = (r_state != IDLE);
    assign levelDone         = r_done;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
            r_lfsr  <= LFSR_SEED;
            r_quota <= '0;
            r_gap   <= '0;
            r_cnt   <= '0;
            r_vec   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
            r_done <= 1'b0;
            r_vec  <= w_vec_next;
            if (endLevel) begin
                r_vec   <= '0;
                r_state <= IDLE;
            end else if (startOfLevel) begin
                r_vec   <= '0;
                r_quota <= w_quota;
                r_cnt   <= '0;
                r_gap   <= w_gap_load;
                r_state <= (w_quota == 5'd0) ? DRAIN : WAIT_GAP;
            end else begin
                case (r_state)
                    WAIT_GAP: if (oneTensSec) begin
                        r_gap <= r_gap - 5'd1;
                        if (r_gap == 5'd1) r_state <= RELEASE;
                    end
                    RELEASE: begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == r_quota) r_state <= DRAIN;
                        else begin
                            r_gap   <= w_gap_load;
                            r_state <= WAIT_GAP;
                        end
                    end
                    DRAIN: if (w_vec_next == '0) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trees_spawn_scheduler.sv
// tb_trees_spawn_scheduler: directed vectors with hand-computed expectations; GAP_MASK=0 gives
// a fixed gap of 3 ticks between releases.
module tb_trees_spawn_scheduler;
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfLevel = 1'b0;
    logic        endLevel = 1'b0;
    logic        oneTensSec = 1'b0;
    logic [3:0]  levelNumber = 4'd0;
    logic [15:0] treeRetireVector = '0;
    logic [15:0] enableTreesVector;
    logic [4:0]  releasedCount;
    logic        busy;
    logic        levelDone;
    int          n_checks = 0;
    int          n_errors = 0;

    trees_spawn_scheduler #(.GAP_MASK(0)) dut (
        .clk(clk), .resetN(resetN), .startOfLevel(startOfLevel), .endLevel(endLevel),
        .oneTensSec(oneTensSec), .levelNumber(levelNumber), .treeRetireVector(treeRetireVector),
        .enableTreesVector(enableTreesVector), .releasedCount(releasedCount),
        .busy(busy), .levelDone(levelDone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_level(input logic [3:0] lvl);
        @(negedge clk);
        levelNumber  = lvl;
        startOfLevel = 1'b1;
        @(negedge clk);
        startOfLevel = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        oneTensSec = 1'b1;
        @(negedge clk);
        oneTensSec = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            repeat (9) @(negedge clk);
        end
    endtask

    task automatic retire(input logic [15:0] v);
        @(negedge clk);
        treeRetireVector = v;
        @(negedge clk);
        treeRetireVector = '0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_vec", enableTreesVector, 0);
        check("rst_cnt", releasedCount, 0);
        check("rst_busy", busy, 0);
        check("rst_done", levelDone, 0);
        resetN = 1'b1;

        // level 0: quota 4
        start_level(4'd0);
        check("a_busy", busy, 1);
        tick_n(2);
        tick();
        check("a_release_cycle", enableTreesVector, 16'h0000);
        @(negedge clk);
        check("a_bit0", enableTreesVector, 16'h0001);
        check("a_cnt1", releasedCount, 1);
        repeat (8) @(negedge clk);
        tick_n(3);
        check("a_tick6", enableTreesVector, 16'h0003);
        tick_n(3);
        check("a_tick9", enableTreesVector, 16'h0007);
        tick_n(3);
        check("a_tick12", enableTreesVector, 16'h000F);
        check("a_cnt4", releasedCount, 4);
        tick_n(3);
        check("a_tick15", enableTreesVector, 16'h000F);
        check("a_drain_busy", busy, 1);

        retire(16'h0004);
        check("b_vec_b", enableTreesVector, 16'h000B);
        check("b_no_done", levelDone, 0);
        retire(16'h000B);
        check("b_vec_0", enableTreesVector, 16'h0000);
        check("b_done", levelDone, 1);
        @(negedge clk);
        check("b_done_once", levelDone, 0);
        check("b_idle", busy, 0);

        // retire bit0 in the RELEASE cycle of the 4th tree
        start_level(4'd0);
        tick_n(11);
        check("c_vec7", enableTreesVector, 16'h0007);
        tick();
        treeRetireVector = 16'h0001;
        @(negedge clk);
        treeRetireVector = '0;
        check("c_vec_e", enableTreesVector, 16'h000E);
        check("c_cnt4", releasedCount, 4);
        retire(16'h000E);
        check("c_done", levelDone, 1);

        // endLevel during WAIT_GAP
        start_level(4'd0);
        tick_n(7);
        check("d_vec3", enableTreesVector, 16'h0003);
        @(negedge clk);
        endLevel = 1'b1;
        @(negedge clk);
        endLevel = 1'b0;
        check("d_vec0", enableTreesVector, 0);
        check("d_busy", busy, 0);
        check("d_cnt_held", releasedCount, 2);
        check("d_no_done", levelDone, 0);
        tick_n(6);
        check("d_ticks_ignored", enableTreesVector, 0);
        check("d_still_idle", busy, 0);
        @(negedge clk);
        endLevel     = 1'b1;
        startOfLevel = 1'b1;
        @(negedge clk);
        endLevel     = 1'b0;
        startOfLevel = 1'b0;
        check("d_end_wins", busy, 0);
        tick_n(3);
        check("d_end_wins_vec", enableTreesVector, 0);

        // asynchronous reset mid-WAIT_GAP with bits 0..2 set
        start_level(4'd0);
        tick_n(10);
        check("e_vec7", enableTreesVector, 16'h0007);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        check("e_vec", enableTreesVector, 0);
        check("e_cnt", releasedCount, 0);
        check("e_busy", busy, 0);
        check("e_done", levelDone, 0);
        @(negedge clk);
        resetN = 1'b1;
        tick_n(3);
        check("e_idle", busy, 0);
        check("e_idle_vec", enableTreesVector, 0);

        // level 15 clamps to 16 trees
        start_level(4'd15);
        tick_n(48);
        check("f_full", enableTreesVector, 16'hFFFF);
        check("f_cnt16", releasedCount, 16);
        retire(16'h0020);
        check("f_bit5", enableTreesVector, 16'hFFDF);
        tick_n(47);
        check("f_bit5_stays", enableTreesVector, 16'hFFDF);
        check("f_cnt_stays", releasedCount, 16);
        retire(16'hFFDF);
        check("f_done", levelDone, 1);
        check("f_vec0", enableTreesVector, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
